tetris_board: RTL and testbench
===============================

# tetris_board

Playfield engine at the consuming end of the `right`/`left` move interface produced by the button logic. It owns an 8x8 (parameterisable) board bitmap and a single-cell falling piece. It applies move requests, runs gravity, locks pieces, clears full rows, detects game over, and drives a row-scanned LED matrix. It instantiates beside the button logic under the top level and takes that block's `right`/`left` outputs directly.

## Interface
- COLS, 8: board width; one `led_col` bit per column.
- ROWS, 8: board height; row 0 is the top row.
- DROP_DIV, 25_000_000: clock cycles per gravity tick; must be ≥ 2.
- SCAN_DIV, 50_000: clock cycles per display row.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- right  in  1  move-right request level from the button logic.
- left  in  1  move-left request level from the button logic.
- led_row  out  ROWS  one-hot active-high row select.
- led_col  out  COLS  active-high column data for the selected row.
- score  out  8  count of cleared rows; saturates at 255.
- game_over  out  1  high while in OVER.

## Operation
- Move inputs are treated as levels. A rising edge is detected internally, using the registered previous value.
- A move is accepted only on a rising edge, and at most one cell is moved per edge.
- States are SPAWN, FALL, LOCK, CLEAR and OVER.
- SPAWN (1 cycle):
  - Piece is placed at row 0, column COLS/2.
  - If that cell is occupied, go to OVER; otherwise go to FALL.
  - The gravity counter clears on entering FALL.
- FALL, horizontal moves:
  - A right edge moves to col+1 unless col = COLS-1 or that cell is occupied.
  - A left edge moves to col−1 unless col = 0 or that cell is occupied.
  - A blocked move is dropped silently; it is not queued.
  - If right and left edges occur in the same cycle, both are ignored.
- FALL, gravity tick:
  - The tick fires when the counter reaches DROP_DIV−1; the counter then wraps to 0.
  - If row = ROWS−1 or the cell below is occupied, go to LOCK; otherwise row+1.
- Tick and accepted move in the same cycle: the move is applied and the tick is held pending. It is evaluated next cycle against the new column. Only one pending tick is held.
- LOCK (1 cycle): set board[row][col], then go to CLEAR.
- CLEAR (1 cycle):
  - Only the locked row is examined.
  - If that row is all ones, rows 0..row−1 shift down by one and row 0 is zeroed. Score increments, saturating at 255.
  - Then go to SPAWN.
- OVER: the board is frozen, move inputs are ignored and `game_over` is 1. OVER exits only via rst.
- Display:
  - The scan counter advances `scan_row` every SCAN_DIV cycles, wrapping from ROWS−1 to 0.
  - `led_col` = board[scan_row], OR'd with the piece bit when state is FALL and row = scan_row.
  - The piece is not shown in SPAWN, LOCK or CLEAR.
- Reset values:
  - Board all zero, state SPAWN, piece at (0, COLS/2).
  - score = 0, game_over = 0, led_row = 1 (row 0), led_col = 0.
  - Gravity and scan counters 0, pending tick cleared, edge-detect history 0.
  - Reset during any state, including OVER or mid-CLEAR, restores these values on the next edge.

## Timing
- A move edge is seen at clock edge N; the piece column updates at edge N+1, since edge detection is registered.
- SPAWN→FALL is 1 cycle. Lock to next spawn takes 3 cycles: LOCK, CLEAR, SPAWN.
- `led_row`/`led_col` are registered, with 1 cycle latency from board or piece change.
- `score` updates on the edge that leaves CLEAR. `game_over` rises on the edge that enters OVER.

## Configuration
- `TETRIS_OVER_BLINK_EN` defined:
  - In OVER, `led_col` is forced to 0 during alternate gravity periods.
  - The gravity counter keeps running in OVER, and blanking toggles on each tick.
- Undefined: the OVER display is static and the gravity counter is held at 0 in OVER.

## Structure
- Shared package `tetris_pkg`: state enum `tetris_state_t`, default COLS/ROWS/DROP_DIV/SCAN_DIV constants, `SCORE_W = 8`.
- One sub-module, `tetris_row_scan`: scan counter, one-hot `led_row` and the registered `led_col` mux. It takes the board row and piece overlay as inputs.

## Test plan
Bench parameters: COLS=8, ROWS=8, DROP_DIV=4, SCAN_DIV=2.
- Reset, then idle → piece at column 4 falls one row every 4 cycles, locks at row 7, and board[7] = 8'b0001_0000 (bit 4).
- Five right pulses during the first fall → the column stops at 7; the extra pulses are dropped and the lock lands at board[7] bit 7.
- `right` and `left` rising in the same cycle → column unchanged. A move edge coinciding with a tick → column updates and the row advances one cycle later.
- Fill row 7 bits 0–6, then drop a piece to column 7 → row 7 clears, rows above shift down, score = 1.
- Stack column 4 until the spawn cell is occupied → OVER, `game_over` = 1, later moves ignored; rst → all reset values restored.
- Load board[3] = 8'hA5 and scan → `led_col` = 8'hA5 exactly while `led_row` = 8'b0000_1000.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared definitions for the tetris playfield engine.
//   - tetris_state_t : playfield state machine encoding
//   - DEF_*          : default board geometry and timing dividers
//   - SCORE_W        : width of the cleared-row score counter
package tetris_pkg;

  localparam int DEF_COLS     = 8;
  localparam int DEF_ROWS     = 8;
  localparam int DEF_DROP_DIV = 25_000_000;
  localparam int DEF_SCAN_DIV = 50_000;
  localparam int SCORE_W      = 8;

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_FALL  = 3'd1,
    ST_LOCK  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } tetris_state_t;

endpackage

// File: rtl/tetris_row_scan.sv
// tetris_row_scan: row-scanned LED matrix driver.
//   clk, rst       : system clock, synchronous active-high reset
//   row_data_i     : board bits of the row currently being scanned
//   overlay_i      : falling-piece bits to OR onto that row
//   blank_i        : forces the column data to zero
//   scan_row_o     : index of the row being scanned (selects row_data_i)
//   led_row_o      : registered one-hot row select (row 0 after reset)
//   led_col_o      : registered column data for the selected row
module tetris_row_scan import tetris_pkg::*; #(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] row_data_i,
  input  logic [COLS-1:0] overlay_i,
  input  logic            blank_i,
  output logic [RW-1:0]   scan_row_o,
  output logic [ROWS-1:0] led_row_o,
  output logic [COLS-1:0] led_col_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0]   scnt_q, scnt_d;
  logic [RW-1:0]   srow_q, srow_d;
  logic [ROWS-1:0] led_row_q;
  logic [COLS-1:0] led_col_q;

  always_comb begin
    scnt_d = scnt_q + SW'(1);
    srow_d = srow_q;
    if (scnt_q == SW'(SCAN_DIV - 1)) begin
      scnt_d = '0;
      srow_d = (srow_q == RW'(ROWS - 1)) ? '0 : srow_q + RW'(1);
    end
  end

  // Row select and column data are both taken from the pre-edge scan row,
  // so the pair on the outputs always describes the same row.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q    <= '0;
      srow_q    <= '0;
      led_row_q <= ROWS'(1);
      led_col_q <= '0;
    end else begin
      scnt_q    <= scnt_d;
      srow_q    <= srow_d;
      led_row_q <= ROWS'(1) << srow_q;
      led_col_q <= blank_i ? '0 : (row_data_i | overlay_i);
    end
  end

  assign scan_row_o = srow_q;
  assign led_row_o  = led_row_q;
  assign led_col_o  = led_col_q;

endmodule

// File: rtl/tetris_board.sv
// tetris_board: playfield engine fed by the button logic's right/left levels.
// Owns the board bitmap and a single-cell falling piece; applies moves,
// gravity, locking, row clearing and game-over, and drives the LED matrix.
//   clk, rst   : system clock, synchronous active-high reset
//   right,left : move request levels (acted on at rising edges)
//   led_row    : one-hot active-high row select
//   led_col    : active-high column data for the selected row
//   score      : cleared-row count, saturating
//   game_over  : high while in the OVER state
// Optional: define TETRIS_OVER_BLINK_EN to blank the display on alternate
// gravity periods while in OVER.
module tetris_board import tetris_pkg::*; #(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int DROP_DIV = DEF_DROP_DIV,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               right,
  input  logic               left,
  output logic [ROWS-1:0]    led_row,
  output logic [COLS-1:0]    led_col,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int GW = $clog2(DROP_DIV);
  localparam logic [CW-1:0] SPAWN_COL = CW'(COLS / 2);

  tetris_state_t      state_q, state_d;
  logic [COLS-1:0]    board_q [ROWS];
  logic [COLS-1:0]    board_d [ROWS];
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [GW-1:0]      grav_q, grav_d;
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               r_q, r_prev_q, l_q, l_prev_q;
  logic               blank;

  logic               r_edge, l_edge, tick, can_r, can_l, blocked_down;
  logic [GW-1:0]      grav_next;
  logic [RW-1:0]      row_below;
  logic [CW-1:0]      col_rt, col_lt;
  logic [RW-1:0]      scan_row;
  logic [COLS-1:0]    overlay;

  assign r_edge    = r_q & ~r_prev_q;
  assign l_edge    = l_q & ~l_prev_q;
  assign tick      = (grav_q == GW'(DROP_DIV - 1));
  assign grav_next = tick ? '0 : grav_q + GW'(1);
  assign row_below = row_q + RW'(1);
  assign col_rt    = col_q + CW'(1);
  assign col_lt    = col_q - CW'(1);

  // Simultaneous right and left edges cancel; a blocked move is simply lost.
  assign can_r = r_edge & ~l_edge & (col_q != CW'(COLS - 1)) & ~board_q[row_q][col_rt];
  assign can_l = l_edge & ~r_edge & (col_q != '0) & ~board_q[row_q][col_lt];
  assign blocked_down = (row_q == RW'(ROWS - 1)) | board_q[row_below][col_q];

`ifdef TETRIS_OVER_BLINK_EN
  logic blank_q, blank_d;
  assign blank = (state_q == ST_OVER) & blank_q;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    row_d   = row_q;
    col_d   = col_q;
    grav_d  = grav_q;
    pend_d  = pend_q;
    score_d = score_q;
`ifdef TETRIS_OVER_BLINK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      ST_SPAWN: begin
        row_d   = '0;
        col_d   = SPAWN_COL;
        grav_d  = '0;
        pend_d  = 1'b0;
        state_d = board_q[0][SPAWN_COL] ? ST_OVER : ST_FALL;
      end
      ST_FALL: begin
        grav_d = grav_next;
        // An accepted move wins the cycle; a coinciding tick is deferred one
        // cycle so it is judged against the new column.
        if (can_r) begin
          col_d  = col_rt;
          pend_d = pend_q | tick;
        end else if (can_l) begin
          col_d  = col_lt;
          pend_d = pend_q | tick;
        end else if (tick | pend_q) begin
          pend_d = 1'b0;
          if (blocked_down) state_d = ST_LOCK;
          else              row_d   = row_below;
        end
      end
      ST_LOCK: begin
        board_d[row_q][col_q] = 1'b1;
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (&board_q[row_q]) begin
          for (int unsigned r = 1; r < ROWS; r++) begin
            if (r <= 32'(row_q)) board_d[RW'(r)] = board_q[RW'(r - 1)];
          end
          board_d[0] = '0;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
        state_d = ST_SPAWN;
      end
      ST_OVER: begin
`ifdef TETRIS_OVER_BLINK_EN
        grav_d = grav_next;
        if (tick) blank_d = ~blank_q;
`else
        grav_d = '0;
`endif
      end
      default: state_d = ST_SPAWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SPAWN;
      board_q  <= '{default: '0};
      row_q    <= '0;
      col_q    <= SPAWN_COL;
      grav_q   <= '0;
      pend_q   <= 1'b0;
      score_q  <= '0;
      r_q      <= 1'b0;
      r_prev_q <= 1'b0;
      l_q      <= 1'b0;
      l_prev_q <= 1'b0;
`ifdef TETRIS_OVER_BLINK_EN
      blank_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      row_q    <= row_d;
      col_q    <= col_d;
      grav_q   <= grav_d;
      pend_q   <= pend_d;
      score_q  <= score_d;
      r_q      <= right;
      r_prev_q <= r_q;
      l_q      <= left;
      l_prev_q <= l_q;
`ifdef TETRIS_OVER_BLINK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign overlay = ((state_q == ST_FALL) && (row_q == scan_row)) ? (COLS'(1) << col_q) : '0;

  tetris_row_scan #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row_data_i (board_q[scan_row]),
    .overlay_i  (overlay),
    .blank_i    (blank),
    .scan_row_o (scan_row),
    .led_row_o  (led_row),
    .led_col_o  (led_col)
  );

  assign score     = score_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_tetris_board.sv
// tb_tetris_board: scoreboard bench for tetris_board with a behavioural
// playfield model. The model produces one expected output set per clock;
// a monitor pops and compares on the opposite edge.
module tb_tetris_board;

  localparam int COLS = 8, ROWS = 8, DROP_DIV = 4, SCAN_DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, right = 1'b0, left = 1'b0;
  logic [ROWS-1:0] led_row;
  logic [COLS-1:0] led_col;
  logic [7:0] score;
  logic game_over;

  tetris_board #(.COLS(COLS), .ROWS(ROWS), .DROP_DIV(DROP_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .right(right), .left(left),
    .led_row(led_row), .led_col(led_col), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROWS-1:0] lrow;
    logic [COLS-1:0] lcol;
    int              score;
    bit              over;
    bit              shown;   // piece overlaid on this row
  } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_fail = 0;

  // ---------------- behavioural model ----------------
  typedef enum int {M_SPAWN, M_FALL, M_LOCK, M_CLEAR, M_OVER} mphase_t;
  mphase_t         m_ph;
  logic [COLS-1:0] mb [ROWS];
  int m_row, m_col, m_grav, m_score, m_scan, m_scnt, m_spawns;
  bit m_pend, m_rs, m_rp, m_ls, m_lp, m_blank;

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) mb[r] = '0;
    m_ph = M_SPAWN; m_row = 0; m_col = COLS / 2; m_grav = 0; m_pend = 0;
    m_score = 0; m_scan = 0; m_scnt = 0; m_spawns = 0;
    m_rs = 0; m_rp = 0; m_ls = 0; m_lp = 0; m_blank = 0;
  endtask

  task automatic model_edge();
    exp_t e;
    bit re, le, tick, moved;
    e.lrow = '0; e.lrow[m_scan] = 1'b1;
    e.lcol = mb[m_scan];
    e.shown = 0;
    if (m_ph == M_FALL && m_row == m_scan) begin e.lcol[m_col] = 1'b1; e.shown = 1; end
    if (m_ph == M_OVER && m_blank) e.lcol = '0;
    if (rst) begin
      model_reset();
      e.lrow = 1; e.lcol = '0; e.shown = 0; e.score = 0; e.over = 0;
      sb.push_back(e);
      return;
    end
    re = m_rs && !m_rp; le = m_ls && !m_lp;
    m_rp = m_rs; m_rs = right; m_lp = m_ls; m_ls = left;
    case (m_ph)
      M_SPAWN: begin
        m_row = 0; m_col = COLS / 2; m_grav = 0; m_pend = 0;
        if (mb[0][COLS/2]) m_ph = M_OVER;
        else begin m_ph = M_FALL; m_spawns++; end
      end
      M_FALL: begin
        tick = (m_grav == DROP_DIV - 1);
        m_grav = tick ? 0 : m_grav + 1;
        moved = 0;
        if (re && !le && m_col < COLS - 1 && !mb[m_row][m_col+1]) begin m_col++; moved = 1; end
        else if (le && !re && m_col > 0 && !mb[m_row][m_col-1]) begin m_col--; moved = 1; end
        if (moved) m_pend = m_pend || tick;
        else if (tick || m_pend) begin
          m_pend = 0;
          if (m_row == ROWS - 1 || mb[m_row+1][m_col]) m_ph = M_LOCK;
          else m_row++;
        end
      end
      M_LOCK: begin mb[m_row][m_col] = 1'b1; m_ph = M_CLEAR; end
      M_CLEAR: begin
        if (&mb[m_row]) begin
          for (int r = m_row; r > 0; r--) mb[r] = mb[r-1];
          mb[0] = '0;
          if (m_score < 255) m_score++;
        end
        m_ph = M_SPAWN;
      end
      default: begin
`ifdef TETRIS_OVER_BLINK_EN
        if (m_grav == DROP_DIV - 1) begin m_grav = 0; m_blank = !m_blank; end
        else m_grav++;
`endif
      end
    endcase
    if (m_scnt == SCAN_DIV - 1) begin m_scnt = 0; m_scan = (m_scan + 1) % ROWS; end
    else m_scnt++;
    e.score = m_score; e.over = (m_ph == M_OVER);
    sb.push_back(e);
  endtask

  always @(posedge clk) model_edge();

  // ---------------- monitor ----------------
  int probe_row = -1;
  logic [COLS-1:0] probe_val;
  bit probe_done;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("led_row", int'(led_row), int'(it.lrow));
      chk("led_col", int'(led_col), int'(it.lcol));
      chk("score", int'(score), it.score);
      chk("game_over", int'(game_over), int'(it.over));
      if (probe_row >= 0 && !probe_done && it.lrow[probe_row] && !it.shown) begin
        chk($sformatf("probe_row%0d", probe_row), int'(led_col), int'(probe_val));
        probe_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; right = 0; left = 0;
    repeat (2) @(negedge clk);
    chk("rst_led_row", int'(led_row), 1);
    chk("rst_led_col", int'(led_col), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    rst = 0;
  endtask

  task automatic pulse(input bit is_right);
    @(negedge clk);
    if (is_right) right = 1; else left = 1;
    @(negedge clk);
    right = 0; left = 0;
  endtask

  task automatic wait_new_piece();
    int start = m_spawns;
    int n = 0;
    while (m_spawns == start && n < 400 && m_ph != M_OVER) begin @(negedge clk); n++; end
    if (m_spawns == start) begin
      n_checks++; n_fail++;
      $display("FAIL wait_spawn: spawn count %0d, required above %0d", m_spawns, start);
    end
  endtask

  task automatic place(input int col);
    wait_new_piece();
    if (col > COLS / 2) repeat (col - COLS / 2) pulse(1);
    else repeat (COLS / 2 - col) pulse(0);
  endtask

  task automatic probe(input int r, input logic [COLS-1:0] v);
    probe_val = v; probe_done = 0; probe_row = r;
    for (int n = 0; n < 64 && !probe_done; n++) @(negedge clk);
    if (!probe_done) begin
      n_checks++; n_fail++;
      $display("FAIL probe_row%0d: row never scanned, required %0h", r, v);
    end
    probe_row = -1;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int cols4[9] = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
    int cols6[4] = '{0, 2, 5, 7};
    int n;

    // Idle drop at the spawn column
    do_reset();
    wait_new_piece();
    wait_new_piece();
    probe(7, 8'h10);

    // Five right pulses: stops at the right wall
    do_reset();
    wait_new_piece();
    repeat (5) pulse(1);
    wait_new_piece();
    probe(7, 8'h80);

    // Simultaneous edges cancel; move coinciding with tick
    do_reset();
    wait_new_piece();
    @(negedge clk); right = 1; left = 1;
    @(negedge clk); right = 0; left = 0;
    wait_new_piece();
    probe(7, 8'h10);
    n = 0;
    while (!(m_ph == M_FALL && m_grav == 2) && n < 50) begin @(negedge clk); n++; end
    right = 1;
    @(negedge clk); right = 0;
    wait_new_piece();
    probe(7, 8'h30);

    // Row clear with shift-down
    do_reset();
    foreach (cols4[i]) place(cols4[i]);
    wait_new_piece();
    chk("score_after_clear", int'(score), 1);
    probe(7, 8'h08);
    probe(6, 8'h00);

    // Pattern A5 in rows 3..7
    do_reset();
    foreach (cols6[i]) repeat (5) place(cols6[i]);
    wait_new_piece();
    probe(3, 8'hA5);
    probe(7, 8'hA5);

    // Stack the spawn column to game over
    do_reset();
    n = 0;
    while (m_ph != M_OVER && n < 800) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("game_over_set", int'(game_over), 1);
    pulse(1); pulse(0); pulse(1);
    repeat (20) @(negedge clk);
    probe(0, 8'h10);
    probe(4, 8'h10);
    chk("game_over_held", int'(game_over), 1);
    do_reset();

    // Random play
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      right = ($urandom_range(0, 3) == 0);
      left  = ($urandom_range(0, 3) == 0);
    end
    right = 0; left = 0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
